// File: rtl/alu_operand_sequencer.sv
// Key-driven operand/opcode capture sequencer: collects A, B and opcode from switches,
// runs a start/done handshake with the ALU (with timeout) and holds the result for display.
module alu_operand_sequencer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic                  load_x,
    input  logic [DATA_W-1:0]     sw_data,
    input  logic [OP_W-1:0]       sw_op,
    input  logic                  alu_done,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic [DATA_W-1:0]     op_a,
    output logic [DATA_W-1:0]     op_b,
    output logic [OP_W-1:0]       alu_op,
    output logic                  alu_start,
    output logic [2*DATA_W-1:0]   result_q,
    output logic                  result_valid,
    output logic                  err,
    output logic [2:0]            stage
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        RUN    = 3'd3,
        SHOW   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                start_q, start_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q <= GET_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_q    <= op_d;
            start_q <= start_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_d    = op_q;
        start_d = 1'b0;
        res_d   = res_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            GET_A: if (load_x) begin
                op_a_d  = sw_data;
                state_d = GET_B;
            end
            GET_B: if (load_x) begin
                op_b_d  = sw_data;
                state_d = GET_OP;
            end
            GET_OP: if (load_x) begin
                op_d    = sw_op;
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // done takes priority over the timeout on the final cycle
                if (alu_done) begin
                    res_d   = alu_result;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: if (load_x) begin
                valid_d = 1'b0;
                err_d   = 1'b0;
                state_d = GET_A;
            end
            default: state_d = GET_A;
        endcase
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign alu_op       = op_q;
    assign alu_start    = start_q;
    assign result_q     = res_q;
    assign result_valid = valid_q;
    assign err          = err_q;
    assign stage        = state_q;

endmodule
